// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding and command ROM contents for the OLED power-up sequencer.
package oled_pkg;

    typedef enum logic [3:0] {
        S_OFF,
        S_VDD_WAIT,
        S_RES_LOW,
        S_RES_WAIT,
        S_CMD_A,
        S_VBAT_WAIT,
        S_CMD_B,
        S_READY,
        S_SD_CMD,
        S_SD_VBAT
    } state_t;

    localparam int CMD_A_LEN = 5;
    localparam int CMD_B_LEN = 5;
    localparam logic [0:CMD_A_LEN-1][7:0] CMD_A = {8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1};
    localparam logic [0:CMD_B_LEN-1][7:0] CMD_B = {8'hA1, 8'hC8, 8'hDA, 8'h20, 8'hAF};
    localparam logic [7:0] DISP_OFF = 8'hAE;

    // Any burst state other than the two init bursts is the single-byte display-off burst.
    function automatic logic [7:0] rom_byte(input state_t s, input logic [2:0] i);
        return s == S_CMD_A ? CMD_A[i] : s == S_CMD_B ? CMD_B[i] : DISP_OFF;
    endfunction

    function automatic logic [2:0] rom_last(input state_t s);
        return s == S_CMD_A ? 3'(CMD_A_LEN - 1) : s == S_CMD_B ? 3'(CMD_B_LEN - 1) : 3'd0;
    endfunction

endpackage

// File: rtl/oled_delay_timer.sv
// oled_delay_timer: loadable down-counter; done is high while the count reads zero.
module oled_delay_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = count == '0;

endmodule

// File: rtl/oled_init_sequencer.sv
// oled_init_sequencer: OLED rail/reset/command bring-up, then pass-through of the user byte stream.
// Optional power-down sequence on shutdown_req is enabled by defining OLED_SHUTDOWN_EN.
module oled_init_sequencer
    import oled_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int VDD_DELAY_CYC  = CLK_FREQ / 1000,
    parameter int RES_PULSE_CYC  = CLK_FREQ / 200000,
    parameter int VBAT_DELAY_CYC = CLK_FREQ / 10,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       shutdown_req,
    input  logic       user_valid,
    input  logic [7:0] user_data,
    input  logic       user_dc,
    output logic       user_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       tx_dc,
    input  logic       tx_ready,
    input  logic       tx_idle,
    output logic       oled_vdd,
    output logic       oled_vbat,
    output logic       oled_res,
    output logic       init_done
);

    localparam logic [CNT_W-1:0] VDD_V  = CNT_W'(VDD_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RES_V  = CNT_W'(RES_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] VBAT_V = CNT_W'(VBAT_DELAY_CYC - 1);

    state_t           state;
    logic             tx_valid_r;
    logic [7:0]       tx_data_r;
    logic [2:0]       idx;
    logic [1:0]       guard;
    logic             ready_st;
    logic             burst_st;
    logic             accept;
    logic             burst_done;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;

    assign ready_st   = state == S_READY;
    assign burst_st   = state == S_CMD_A || state == S_CMD_B || state == S_SD_CMD;
    assign accept     = tx_valid_r && tx_ready;
    assign burst_done = burst_st && !tx_valid_r && guard == 2'd0 && tx_idle;

    assign tx_valid   = ready_st ? user_valid : tx_valid_r;
    assign tx_data    = ready_st ? user_data : tx_data_r;
    assign tx_dc      = ready_st && user_dc;
    assign user_ready = ready_st && tx_ready;

    // The timer is loaded on the same edge that enters a delay state, so an N-cycle wait loads N-1.
    assign tmr_load  = (state == S_OFF && start)
                     || ((state == S_VDD_WAIT || state == S_RES_LOW) && tmr_done)
                     || ((state == S_CMD_A || state == S_SD_CMD) && burst_done);
    assign tmr_value = state == S_OFF ? VDD_V
                     : (state == S_CMD_A || state == S_SD_CMD) ? VBAT_V : RES_V;

    oled_delay_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .done    (tmr_done)
    );

`ifndef OLED_SHUTDOWN_EN
    logic unused_shutdown;
    assign unused_shutdown = shutdown_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_OFF;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            idx        <= 3'd0;
            guard      <= 2'd0;
            oled_vdd   <= 1'b0;
            oled_vbat  <= 1'b0;
            oled_res   <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            case (state)
                S_OFF: if (start) begin
                    state    <= S_VDD_WAIT;
                    oled_vdd <= 1'b1;
                end
                S_VDD_WAIT: if (tmr_done) begin
                    state    <= S_RES_LOW;
                    oled_res <= 1'b0;
                end
                S_RES_LOW: if (tmr_done) begin
                    state    <= S_RES_WAIT;
                    oled_res <= 1'b1;
                end
                S_RES_WAIT: if (tmr_done) begin
                    state      <= S_CMD_A;
                    tx_valid_r <= 1'b1;
                    tx_data_r  <= rom_byte(S_CMD_A, 3'd0);
                    idx        <= 3'd0;
                end
                S_VBAT_WAIT: if (tmr_done) begin
                    state      <= S_CMD_B;
                    tx_valid_r <= 1'b1;
                    tx_data_r  <= rom_byte(S_CMD_B, 3'd0);
                    idx        <= 3'd0;
                end
                // After the last accept the serializer may not yet report busy, so tx_idle is masked for two cycles.
                S_CMD_A, S_CMD_B, S_SD_CMD: begin
                    if (accept) begin
                        if (idx == rom_last(state)) begin
                            tx_valid_r <= 1'b0;
                            guard      <= 2'd2;
                        end else begin
                            idx       <= idx + 3'd1;
                            tx_data_r <= rom_byte(state, idx + 3'd1);
                        end
                    end else if (guard != 2'd0) begin
                        guard <= guard - 2'd1;
                    end else if (burst_done) begin
                        state     <= state == S_CMD_A ? S_VBAT_WAIT : state == S_CMD_B ? S_READY : S_SD_VBAT;
                        oled_vbat <= state != S_SD_CMD;
                        init_done <= state == S_CMD_B;
                    end
                end
`ifdef OLED_SHUTDOWN_EN
                S_READY: if (shutdown_req) begin
                    state      <= S_SD_CMD;
                    init_done  <= 1'b0;
                    tx_valid_r <= 1'b1;
                    tx_data_r  <= DISP_OFF;
                    idx        <= 3'd0;
                end
                S_SD_VBAT: if (tmr_done) begin
                    state    <= S_OFF;
                    oled_vdd <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
